// File: rtl/agnus_sprite_dma.sv
`default_nettype none
// ============================================================================
// Module   : agnus_sprite_dma
// Brief    : Sprite DMA engine. Two chip-RAM fetch slots per sprite per line,
//            control/image words streamed onto the register bus, per-sprite
//            vertical start/stop tracking, CPU/copper register snooping.
// Revision : 1.0 - initial release
// ============================================================================
module agnus_sprite_dma #(
  parameter logic [8:0] SPRPTBASE     = 9'h120,
  parameter logic [8:0] SPRPOSCTLBASE = 9'h140,
  parameter logic [7:0] SLOTBASE      = 8'h15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic [8:0]  hpos,
  input  logic [8:0]  vpos,
  input  logic [8:0]  vbl_end,
  input  logic        sprdma_en,
  input  logic [7:0]  reg_address_in,
  input  logic [15:0] data_in,
  input  logic [15:0] chip_data_in,
  output logic        dma,
  output logic [20:1] address_out,
  output logic [7:0]  reg_address_out
);

  // Register-bus addresses are word addresses ([8:1]).
  localparam logic [7:0] c_PT_REG     = SPRPTBASE[8:1];
  localparam logic [7:0] c_POSCTL_REG = SPRPOSCTLBASE[8:1];
  localparam logic [7:0] c_NOP_REG    = 8'hFF;

  // Offset of the destination register within a sprite's POS/CTL/DATA/DATB block.
  localparam logic [1:0] c_SEL_POS  = 2'd0;
  localparam logic [1:0] c_SEL_CTL  = 2'd1;
  localparam logic [1:0] c_SEL_DATA = 2'd2;
  localparam logic [1:0] c_SEL_DATB = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_FETCH_CTL  = 2'd1,
    S_WAIT       = 2'd2,
    S_FETCH_DATA = 2'd3
  } sprite_state_t;

  logic [20:1]   r_ptr    [8];
  logic [8:0]    r_vstart [8];
  logic [8:0]    r_vstop  [8];
  sprite_state_t r_state  [8];

  logic [7:0]    w_slot_off;
  logic          w_slot_hit;
  logic          w_slot_b;
  logic [2:0]    w_sel;
  logic          w_usable;
  logic          w_force;
  logic [20:1]   w_sel_ptr;
  logic [8:0]    w_sel_vstart;
  logic [8:0]    w_sel_vstop;
  sprite_state_t w_sel_state;
  logic          w_req;
  logic [1:0]    w_reg_sel;
  sprite_state_t w_next_state;
  logic          w_unused;

  // Slot decode: sprite n owns even color clocks SLOTBASE+4n (A) and +4n+2 (B).
  // Color clocks below SLOTBASE wrap to a large offset and never hit.
  assign w_slot_off = hpos[8:1] - SLOTBASE;
  assign w_slot_hit = (w_slot_off[7:5] == 3'b000) && !w_slot_off[0];
  assign w_slot_b   = w_slot_off[1];
  assign w_sel      = w_slot_off[4:2];
  assign w_usable   = sprdma_en && (vpos >= vbl_end);
  assign w_force    = (vpos == vbl_end);

  assign w_sel_ptr    = r_ptr[w_sel];
  assign w_sel_vstart = r_vstart[w_sel];
  assign w_sel_vstop  = r_vstop[w_sel];
  assign w_sel_state  = r_state[w_sel];

  // Chip data bits that carry no sprite control information.
  assign w_unused = ^{chip_data_in[7:3], chip_data_in[0]};

  // Slot request decision and the state the owning sprite moves to after it.
  always_comb begin
    w_req        = 1'b0;
    w_reg_sel    = c_SEL_POS;
    w_next_state = w_sel_state;
    if (w_slot_hit && w_usable) begin
      if (!w_slot_b) begin
        if (w_force) begin
          // First line of sprite DMA restarts every sprite's control fetch.
          w_req        = 1'b1;
          w_reg_sel    = c_SEL_POS;
          w_next_state = S_FETCH_CTL;
        end else begin
          case (w_sel_state)
            S_FETCH_CTL: begin
              w_req     = 1'b1;
              w_reg_sel = c_SEL_POS;
            end
            S_WAIT: begin
              // Stop has priority: a start that coincides with stop is ignored.
              if ((vpos == w_sel_vstart) && (vpos != w_sel_vstop)) begin
                w_req        = 1'b1;
                w_reg_sel    = c_SEL_DATA;
                w_next_state = S_FETCH_DATA;
              end
            end
            S_FETCH_DATA: begin
              w_req = 1'b1;
              if (vpos == w_sel_vstop) begin
                w_reg_sel    = c_SEL_POS;
                w_next_state = S_FETCH_CTL;
              end else begin
                w_reg_sel = c_SEL_DATA;
              end
            end
            default: ;
          endcase
        end
      end else begin
        case (w_sel_state)
          S_FETCH_CTL: begin
            w_req        = 1'b1;
            w_reg_sel    = c_SEL_CTL;
            w_next_state = S_WAIT;
          end
          S_FETCH_DATA: begin
            w_req     = 1'b1;
            w_reg_sel = c_SEL_DATB;
          end
          default: ;
        endcase
      end
    end
  end

  assign dma             = w_req;
  assign address_out     = w_req ? w_sel_ptr : 20'h00000;
  assign reg_address_out = w_req ? (c_POSCTL_REG + {3'b000, w_sel, w_reg_sel}) : c_NOP_REG;

  // Per-sprite state: DMA updates at the phase-1 edge, then CPU snoops (CPU wins).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        r_ptr[i]    <= 20'h00000;
        r_vstart[i] <= 9'h000;
        r_vstop[i]  <= 9'h000;
        r_state[i]  <= S_IDLE;
      end
    end else if (clk7_en) begin
      if (hpos[0] && w_req) begin
        r_ptr[w_sel]   <= w_sel_ptr + 20'd1;
        r_state[w_sel] <= w_next_state;
        if (w_reg_sel == c_SEL_POS) begin
          r_vstart[w_sel][7:0] <= chip_data_in[15:8];
        end
        if (w_reg_sel == c_SEL_CTL) begin
          r_vstop[w_sel][7:0] <= chip_data_in[15:8];
          r_vstart[w_sel][8]  <= chip_data_in[2];
          r_vstop[w_sel][8]   <= chip_data_in[1];
        end
      end
      for (int i = 0; i < 8; i++) begin
        if (reg_address_in == (c_PT_REG + 8'(2 * i))) begin
          r_ptr[i][20:16] <= data_in[4:0];
        end
        if (reg_address_in == (c_PT_REG + 8'(2 * i + 1))) begin
          r_ptr[i][15:1] <= data_in[15:1];
        end
        if (reg_address_in == (c_POSCTL_REG + 8'(4 * i))) begin
          r_vstart[i][7:0] <= data_in[15:8];
        end
        if (reg_address_in == (c_POSCTL_REG + 8'(4 * i + 1))) begin
          r_vstop[i][7:0] <= data_in[15:8];
          r_vstart[i][8]  <= data_in[2];
          r_vstop[i][8]   <= data_in[1];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_agnus_sprite_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_agnus_sprite_dma
// Brief    : Directed self-checking bench for agnus_sprite_dma. Lines are
//            swept over the sprite slot region; each 7 MHz step is two clk
//            cycles, the second carrying clk7_en.
// Revision : 1.0 - initial release
// ============================================================================
module tb_agnus_sprite_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk7_en;
  logic [8:0]  hpos;
  logic [8:0]  vpos;
  logic [8:0]  vbl_end;
  logic        sprdma_en;
  logic [7:0]  reg_address_in;
  logic [15:0] data_in;
  logic [15:0] chip_data_in;
  logic        dma;
  logic [20:1] address_out;
  logic [7:0]  reg_address_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Chip RAM model: word address -> data; unwritten words read as zero.
  logic [15:0] mem [int];

  // Phase-0 samples of one line, indexed by color clock.
  logic        obs_dma  [256];
  logic [7:0]  obs_reg  [256];
  logic [19:0] obs_addr [256];
  int          line_dma_cnt;

  // Optional CPU write injected at the phase-1 edge of a chosen color clock.
  logic        inj_en;
  logic [7:0]  inj_cc;
  logic [7:0]  inj_addr;
  logic [15:0] inj_data;

  agnus_sprite_dma dut (
    .clk             (clk),
    .reset           (reset),
    .clk7_en         (clk7_en),
    .hpos            (hpos),
    .vpos            (vpos),
    .vbl_end         (vbl_end),
    .sprdma_en       (sprdma_en),
    .reg_address_in  (reg_address_in),
    .data_in         (data_in),
    .chip_data_in    (chip_data_in),
    .dma             (dma),
    .address_out     (address_out),
    .reg_address_out (reg_address_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rd(input logic [19:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return 16'h0000;
  endfunction

  // One 7 MHz step: an idle clk edge, then the clk7_en edge, then hpos+1.
  task automatic step7();
    @(posedge clk); #1;
    clk7_en      = 1'b1;
    chip_data_in = rd(address_out);
    @(posedge clk); #1;
    clk7_en = 1'b0;
    hpos    = hpos + 9'd1;
    #1;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [15:0] d);
    hpos           = 9'h000;
    reg_address_in = a;
    data_in        = d;
    step7();
    reg_address_in = 8'hFF;
    data_in        = 16'h0000;
  endtask

  // Sweep color clocks $10..$37 of line v, recording phase-0 outputs.
  task automatic run_line(input logic [8:0] v);
    vpos = v;
    hpos = 9'h020;
    line_dma_cnt = 0;
    #1;
    for (int i = 0; i < 80; i++) begin
      if (!hpos[0]) begin
        obs_dma[hpos[8:1]]  = dma;
        obs_reg[hpos[8:1]]  = reg_address_out;
        obs_addr[hpos[8:1]] = address_out;
        if (dma) line_dma_cnt++;
      end
      if (inj_en && (hpos == {inj_cc, 1'b1})) begin
        reg_address_in = inj_addr;
        data_in        = inj_data;
      end
      step7();
      reg_address_in = 8'hFF;
      data_in        = 16'h0000;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step7();
    reset = 1'b0;
    #1;
    n_checks++; if (dma !== 1'b0) begin n_fail++; $display("FAIL reset_dma: got %b expected 0", dma); end
    n_checks++; if (reg_address_out !== 8'hFF) begin n_fail++; $display("FAIL reset_reg: got %h expected ff", reg_address_out); end
    n_checks++; if (address_out !== 20'h00000) begin n_fail++; $display("FAIL reset_addr: got %h expected 00000", address_out); end
    run_line(9'h018);
    n_checks++; if (line_dma_cnt !== 0) begin n_fail++; $display("FAIL idle_before_vbl_end: got %0d requests expected 0", line_dma_cnt); end
    run_line(9'h01A);
    n_checks++; if (line_dma_cnt !== 0) begin n_fail++; $display("FAIL idle_not_vbl_end_line: got %0d requests expected 0", line_dma_cnt); end
  endtask

  task automatic test_ctl_fetch();
    vpos = 9'h000;
    cpu_write(8'h90, 16'h0000);   // SPR0PTH
    cpu_write(8'h91, 16'h1000);   // SPR0PTL -> word 0x00800
    cpu_write(8'h92, 16'h0000);   // SPR1PTH
    cpu_write(8'h93, 16'h1400);   // SPR1PTL -> word 0x00A00
    cpu_write(8'h96, 16'h0000);   // SPR3PTH
    cpu_write(8'h97, 16'h1200);   // SPR3PTL -> word 0x00900
    run_line(9'h019);
    n_checks++; if (obs_dma[8'h15] !== 1'b1) begin n_fail++; $display("FAIL ctl_dma_a: got %b expected 1", obs_dma[8'h15]); end
    n_checks++; if (obs_addr[8'h15] !== 20'h00800) begin n_fail++; $display("FAIL ctl_addr_a: got %h expected 00800", obs_addr[8'h15]); end
    n_checks++; if (obs_reg[8'h15] !== 8'hA0) begin n_fail++; $display("FAIL ctl_reg_a: got %h expected a0", obs_reg[8'h15]); end
    n_checks++; if (obs_dma[8'h16] !== 1'b0) begin n_fail++; $display("FAIL ctl_gap: got %b expected 0", obs_dma[8'h16]); end
    n_checks++; if (obs_addr[8'h17] !== 20'h00801) begin n_fail++; $display("FAIL ctl_addr_b: got %h expected 00801", obs_addr[8'h17]); end
    n_checks++; if (obs_reg[8'h17] !== 8'hA1) begin n_fail++; $display("FAIL ctl_reg_b: got %h expected a1", obs_reg[8'h17]); end
    n_checks++; if ({obs_reg[8'h19], obs_addr[8'h19]} !== {8'hA4, 20'h00A00}) begin n_fail++; $display("FAIL ctl_spr1_a: got %h/%h expected a4/00a00", obs_reg[8'h19], obs_addr[8'h19]); end
    n_checks++; if ({obs_reg[8'h23], obs_addr[8'h23]} !== {8'hAD, 20'h00901}) begin n_fail++; $display("FAIL ctl_spr3_b: got %h/%h expected ad/00901", obs_reg[8'h23], obs_addr[8'h23]); end
    n_checks++; if (line_dma_cnt !== 16) begin n_fail++; $display("FAIL ctl_all_forced: got %0d requests expected 16", line_dma_cnt); end
    run_line(9'h020);
    n_checks++; if (line_dma_cnt !== 0) begin n_fail++; $display("FAIL wait_no_dma: got %0d requests expected 0", line_dma_cnt); end
  endtask

  // Sprite 0 displays 0x30..0x4F; sprite 3 displays 0x30..0x31 and takes a
  // CPU SPR3PTL write on the same edge as its last slot-B increment.
  task automatic test_display_run();
    logic [19:0] exp_a;
    for (int l = 9'h030; l <= 9'h04F; l++) begin
      inj_en   = (l == 9'h031);
      inj_cc   = 8'h23;
      inj_addr = 8'h97;
      inj_data = 16'h2000;
      run_line(9'(l));
      inj_en = 1'b0;
      exp_a = 20'h00802 + 20'(2 * (l - 9'h030));
      n_checks++; if ({obs_reg[8'h15], obs_addr[8'h15]} !== {8'hA2, exp_a}) begin n_fail++; $display("FAIL data_a line %h: got %h/%h expected a2/%h", l, obs_reg[8'h15], obs_addr[8'h15], exp_a); end
      n_checks++; if ({obs_reg[8'h17], obs_addr[8'h17]} !== {8'hA3, exp_a + 20'd1}) begin n_fail++; $display("FAIL data_b line %h: got %h/%h expected a3/%h", l, obs_reg[8'h17], obs_addr[8'h17], exp_a + 20'd1); end
      if (l == 9'h030) begin
        n_checks++; if ({obs_reg[8'h21], obs_addr[8'h21]} !== {8'hAE, 20'h00902}) begin n_fail++; $display("FAIL spr3_data_a: got %h/%h expected ae/00902", obs_reg[8'h21], obs_addr[8'h21]); end
      end
      if (l == 9'h031) begin
        n_checks++; if ({obs_reg[8'h23], obs_addr[8'h23]} !== {8'hAF, 20'h00905}) begin n_fail++; $display("FAIL spr3_data_b: got %h/%h expected af/00905", obs_reg[8'h23], obs_addr[8'h23]); end
      end
      if (l == 9'h032) begin
        n_checks++; if ({obs_reg[8'h21], obs_addr[8'h21]} !== {8'hAC, 20'h01000}) begin n_fail++; $display("FAIL cpu_wins_pos: got %h/%h expected ac/01000", obs_reg[8'h21], obs_addr[8'h21]); end
        n_checks++; if ({obs_reg[8'h23], obs_addr[8'h23]} !== {8'hAD, 20'h01001}) begin n_fail++; $display("FAIL cpu_wins_ctl: got %h/%h expected ad/01001", obs_reg[8'h23], obs_addr[8'h23]); end
      end
    end
    run_line(9'h050);
    n_checks++; if ({obs_reg[8'h15], obs_addr[8'h15]} !== {8'hA0, 20'h00842}) begin n_fail++; $display("FAIL vstop_pos: got %h/%h expected a0/00842", obs_reg[8'h15], obs_addr[8'h15]); end
    n_checks++; if ({obs_reg[8'h17], obs_addr[8'h17]} !== {8'hA1, 20'h00843}) begin n_fail++; $display("FAIL vstop_ctl: got %h/%h expected a1/00843", obs_reg[8'h17], obs_addr[8'h17]); end
  endtask

  // Sprite 0 second run 0x60..0x63 with DMA disabled for line 0x61.
  task automatic test_dma_disable();
    run_line(9'h060);
    n_checks++; if ({obs_reg[8'h15], obs_addr[8'h15]} !== {8'hA2, 20'h00844}) begin n_fail++; $display("FAIL run2_first: got %h/%h expected a2/00844", obs_reg[8'h15], obs_addr[8'h15]); end
    sprdma_en = 1'b0;
    run_line(9'h061);
    sprdma_en = 1'b1;
    n_checks++; if (line_dma_cnt !== 0) begin n_fail++; $display("FAIL disabled_no_dma: got %0d requests expected 0", line_dma_cnt); end
    n_checks++; if ({obs_reg[8'h15], obs_addr[8'h15]} !== {8'hFF, 20'h00000}) begin n_fail++; $display("FAIL disabled_idle_bus: got %h/%h expected ff/00000", obs_reg[8'h15], obs_addr[8'h15]); end
    run_line(9'h062);
    n_checks++; if ({obs_reg[8'h15], obs_addr[8'h15]} !== {8'hA2, 20'h00846}) begin n_fail++; $display("FAIL resume_a: got %h/%h expected a2/00846", obs_reg[8'h15], obs_addr[8'h15]); end
    n_checks++; if ({obs_reg[8'h17], obs_addr[8'h17]} !== {8'hA3, 20'h00847}) begin n_fail++; $display("FAIL resume_b: got %h/%h expected a3/00847", obs_reg[8'h17], obs_addr[8'h17]); end
    run_line(9'h063);
    run_line(9'h064);
    n_checks++; if ({obs_reg[8'h15], obs_addr[8'h15]} !== {8'hA0, 20'h0084A}) begin n_fail++; $display("FAIL run2_stop: got %h/%h expected a0/0084a", obs_reg[8'h15], obs_addr[8'h15]); end
  endtask

  // Sprite 1: POS 0x2000 / CTL 0x0006 -> vstart 0x120, vstop 0x100.
  task automatic test_ctl_bit8();
    run_line(9'h100);
    n_checks++; if (obs_dma[8'h19] !== 1'b0) begin n_fail++; $display("FAIL bit8_no_start_at_vstop: got %b expected 0", obs_dma[8'h19]); end
    run_line(9'h11F);
    n_checks++; if (obs_dma[8'h19] !== 1'b0) begin n_fail++; $display("FAIL bit8_no_start_early: got %b expected 0", obs_dma[8'h19]); end
    run_line(9'h120);
    n_checks++; if ({obs_reg[8'h19], obs_addr[8'h19]} !== {8'hA6, 20'h00A02}) begin n_fail++; $display("FAIL bit8_start_a: got %h/%h expected a6/00a02", obs_reg[8'h19], obs_addr[8'h19]); end
    n_checks++; if ({obs_reg[8'h1B], obs_addr[8'h1B]} !== {8'hA7, 20'h00A03}) begin n_fail++; $display("FAIL bit8_start_b: got %h/%h expected a7/00a03", obs_reg[8'h1B], obs_addr[8'h1B]); end
  endtask

  // CPU write to SPR1CTL moves vstop to 0x122 while sprite 1 is displaying.
  task automatic test_cpu_posctl();
    run_line(9'h121);
    n_checks++; if ({obs_reg[8'h19], obs_addr[8'h19]} !== {8'hA6, 20'h00A04}) begin n_fail++; $display("FAIL snoop_pre: got %h/%h expected a6/00a04", obs_reg[8'h19], obs_addr[8'h19]); end
    cpu_write(8'hA5, 16'h2202);
    run_line(9'h122);
    n_checks++; if ({obs_reg[8'h19], obs_addr[8'h19]} !== {8'hA4, 20'h00A06}) begin n_fail++; $display("FAIL snoop_vstop_pos: got %h/%h expected a4/00a06", obs_reg[8'h19], obs_addr[8'h19]); end
    n_checks++; if ({obs_reg[8'h1B], obs_addr[8'h1B]} !== {8'hA5, 20'h00A07}) begin n_fail++; $display("FAIL snoop_vstop_ctl: got %h/%h expected a5/00a07", obs_reg[8'h1B], obs_addr[8'h1B]); end
  endtask

  initial begin
    reset          = 1'b1;
    clk7_en        = 1'b0;
    hpos           = 9'h000;
    vpos           = 9'h000;
    vbl_end        = 9'h019;
    sprdma_en      = 1'b1;
    reg_address_in = 8'hFF;
    data_in        = 16'h0000;
    chip_data_in   = 16'h0000;
    inj_en         = 1'b0;
    inj_cc         = 8'h00;
    inj_addr       = 8'hFF;
    inj_data       = 16'h0000;
    mem[32'h00800] = 16'h3040;   // sprite 0 POS: vstart 0x30
    mem[32'h00801] = 16'h5000;   // sprite 0 CTL: vstop 0x50
    mem[32'h00842] = 16'h6000;   // sprite 0 second POS: vstart 0x60
    mem[32'h00843] = 16'h6400;   // sprite 0 second CTL: vstop 0x64
    mem[32'h00900] = 16'h3000;   // sprite 3 POS: vstart 0x30
    mem[32'h00901] = 16'h3200;   // sprite 3 CTL: vstop 0x32
    mem[32'h00A00] = 16'h2000;   // sprite 1 POS
    mem[32'h00A01] = 16'h0006;   // sprite 1 CTL: vstart[8], vstop[8] set

    test_reset();
    test_ctl_fetch();
    test_display_run();
    test_dma_disable();
    test_ctl_bit8();
    test_cpu_posctl();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/agnus_sprite_dma.md
# agnus_sprite_dma

Sprite DMA engine in Agnus: the bus-side writer that feeds the Denise sprite shifters. Each scanline it runs two chip-RAM fetch slots per sprite (8 sprites), streams control words (SPRxPOS/SPRxCTL) and image words (SPRxDATA/SPRxDATB) onto the register bus, and tracks per-sprite vertical start/stop so Denise only ever receives register writes. The scope is OCS/ECS 16-bit fetches only; wide AGA fetch modes are out of scope.

## Interface
Parameters:
- SPRPTBASE, 9'h120 — SPR0PTH address; sprite n pointer at base+4n (PTH), base+4n+2 (PTL).
- SPRPOSCTLBASE, 9'h140 — SPR0POS address; sprite n POS/CTL/DATA/DATB at base+8n+{0,2,4,6}.
- SLOTBASE, 8'h15 — color clock of sprite 0 slot A.

Ports:
- clk  in  1  28 MHz clock.
- reset  in  1  synchronous, active-high reset.
- clk7_en  in  1  7 MHz enable; all state advances only when high.
- hpos  in  9  hpos[8:1] = color clock, hpos[0] = phase within color clock.
- vpos  in  9  current line.
- vbl_end  in  9  first line with sprite DMA.
- sprdma_en  in  1  DMACON master and sprite enable, ANDed upstream.
- reg_address_in  in  8  CPU/copper register address [8:1], snooped.
- data_in  in  16  CPU/copper register write data.
- chip_data_in  in  16  chip RAM read data, valid at phase-1 cycle of the slot.
- dma  out  1  sprite DMA owns the current slot.
- address_out  out  20  chip RAM word address [20:1].
- reg_address_out  out  8  destination register [8:1]; 8'hFF (NOP, $1FE) when idle.

## Operation
- Slots: sprite n slot A = color clock SLOTBASE+4n, slot B = SLOTBASE+4n+2 (sprite 7 slot B = $33). A slot is usable only if sprdma_en=1 and vpos >= vbl_end.
- Per-sprite registers: ptr[20:1], vstart[8:0], vstop[8:0], state[1:0].
- States: IDLE, FETCH_CTL, WAIT, FETCH_DATA.
- At the start of line vbl_end (first usable slot A), every sprite is forced to FETCH_CTL, regardless of its current state.
- In FETCH_CTL: slot A reads ptr and writes POS (base+8n), loading vstart[7:0]=data[15:8]. Slot B reads ptr and writes CTL (+2), loading vstop[7:0]=data[15:8], vstart[8]=data[2], vstop[8]=data[1]. After slot B, go to WAIT.
- In WAIT: at slot A, if vpos==vstart, go to FETCH_DATA and fetch on this line. Otherwise there is no DMA; dma=0 and the slot is free.
- In FETCH_DATA: at slot A, if vpos==vstop, fetch POS/CTL on this line instead (same as FETCH_CTL), then go to WAIT. Otherwise slot A writes DATA (+4) and slot B writes DATB (+6).
- vstop is checked before vstart. A newly loaded vstart is compared from the next line onward.
- Every completed fetch increments ptr by 1 word, with wrap modulo 2^20.
- Snoop rules:
  - A write to PTH sets ptr[20:16]=data_in[4:0]; a write to PTL sets ptr[15:1]=data_in[15:1]. Both take effect at the next clk7_en.
  - A CPU write and a DMA increment of the same pointer at the same edge: the CPU value wins.
  - A CPU write to POS/CTL updates vstart/vstop with the same bit mapping; the state is unchanged.
- sprdma_en=0: no requests, and state and pointers hold. On re-enable, operation resumes at the next slot.
- IDLE is the reset state. A sprite leaves IDLE only at vbl_end.

## Timing
- Reset: all states IDLE, pointers 0, vstart/vstop 0; dma=0, address_out=0, reg_address_out=8'hFF.
- dma, address_out and reg_address_out are combinational from registered state and hpos. They are valid for both phases of the slot color clock.
- At the phase-1 clk7_en edge: chip_data_in is sampled, ptr increments, and the state updates. The next slot therefore sees the new pointer.
- Latency from slot A to slot B is 2 color clocks. At most 2 fetches per sprite per line.
- Reset mid-slot: outputs return to idle values on the next clk7_en edge; no partial increment.

## Test plan
- Reset: dma=0, reg_address_out=8'hFF, and the IDLE sprite issues no requests through vpos=vbl_end-1.
- Control fetch:
  - Setup: SPR0PT=0x000800 via PTH/PTL, vbl_end=0x19, memory POS=0x3040, CTL=0x5000.
  - On line 0x19: at cc $15, address_out=0x000800 and reg_address_out=0xA0; at cc $17, address_out=0x000801 and reg_address_out=0xA1.
  - Result: vstart=0x30, vstop=0x50, state WAIT.
- Display run:
  - Lines 0x30–0x4F: reg 0xA2 then 0xA3 each line, ptr advancing 2 words/line.
  - Line 0x50: reg 0xA0/0xA1 fetched from ptr 0x000842/0x000843.
- sprdma_en=0 across a display line: dma=0 for all slots, ptr unchanged, fetch resumes the next line after re-enable.
- CPU write to SPR3PTL=0x2000 on the same phase-1 edge as sprite 3 slot-B increment: ptr[15:1]=0x1000, not the incremented value.
- CTL word 0x0006 with POS 0x2000: vstart=0x120, vstop=0x100. Data fetch begins on line 0x120.
